fir_frame_engine: RTL and testbench

FIR_FRAME_ENGINE -- requirements
Module: fir_frame_engine

---
 rtl/fir_frame_engine.sv | 136 +++++++++++++
 tb/tb_fir_frame_engine.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_frame_engine.sv
// rtl/fir_frame_engine.sv - framed FIR filter with fill/run/flush sequencing and a coefficient write port
module fir_frame_engine #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 12,
    parameter int NTAPS     = 32,
    parameter int FRAME_LEN = 1024,
    parameter int FRAC_SH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [DATA_W-1:0]   data,
    input  logic                       data_valid,
    output logic                       data_ready,
    input  logic                       coef_we,
    input  logic [$clog2(NTAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]   coef_wdata,
    output logic                       coef_err,
    output logic signed [DATA_W-1:0]   fir_d,
    output logic                       fir_valid,
    output logic                       frame_done
);
    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = PW + $clog2(NTAPS);
    localparam int CW    = $clog2(FRAME_LEN + 1);
    localparam int FW    = $clog2(NTAPS);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t                    state;
    logic [CW-1:0]             count;
    logic [FW-1:0]             flush_cnt;
    // The oldest tap x[NTAPS-1] is never needed before it is overwritten, so only x[0..NTAPS-2] is stored.
    logic signed [DATA_W-1:0]  taps  [NTAPS-1];
    logic signed [COEF_W-1:0]  coefs [NTAPS];

    logic                      accept;
    logic                      step;
    logic                      addr_ok;
    logic signed [DATA_W-1:0]  shift_in;
    logic signed [DATA_W-1:0]  x_post [NTAPS];
    logic signed [PW-1:0]      prod;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [DATA_W-1:0]  fir_next;
    logic [CW-1:0]             count_next;

    assign data_ready = !rst && (state != FLUSH);
    assign accept     = data_valid && data_ready;
    assign step       = accept || (state == FLUSH);
    assign shift_in   = (state == FLUSH) ? '0 : data;
    assign count_next = count + 1'b1;
    assign addr_ok    = int'(coef_addr) < NTAPS;

    always_comb begin
        x_post[0] = shift_in;
        for (int k = 1; k < NTAPS; k++) begin
            x_post[k] = taps[k-1];
        end
        acc  = '0;
        prod = '0;
        for (int k = 0; k < NTAPS; k++) begin
            prod = PW'(coefs[k]) * PW'(x_post[k]);
            acc  = acc + ACC_W'(prod);
        end
        shifted = acc >>> FRAC_SH;
        if (shifted > SAT_MAX) begin
            fir_next = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            fir_next = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            fir_next = shifted[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            flush_cnt  <= '0;
            fir_d      <= '0;
            fir_valid  <= 1'b0;
            frame_done <= 1'b0;
            coef_err   <= 1'b0;
            for (int k = 0; k < NTAPS - 1; k++) taps[k] <= '0;
            for (int k = 0; k < NTAPS; k++) coefs[k] <= '0;
        end else begin
            fir_valid  <= 1'b0;
            frame_done <= 1'b0;
            coef_err   <= 1'b0;

            // Coefficients may only change between frames.
            if (coef_we) begin
                if (state == IDLE && addr_ok) coefs[coef_addr] <= coef_wdata;
                else                          coef_err <= 1'b1;
            end

            if (step) begin
                taps[0] <= shift_in;
                for (int k = 1; k < NTAPS - 1; k++) taps[k] <= taps[k-1];
            end

            case (state)
                IDLE: if (accept) begin
                    count <= CW'(1);
                    state <= (NTAPS == 2) ? RUN : FILL;
                end
                FILL: if (accept) begin
                    count <= count_next;
                    if (count_next == CW'(NTAPS - 1)) state <= RUN;
                end
                RUN: if (accept) begin
                    count     <= count_next;
                    fir_valid <= 1'b1;
                    fir_d     <= fir_next;
                    if (count_next == CW'(FRAME_LEN)) begin
                        state     <= FLUSH;
                        flush_cnt <= '0;
                    end
                end
                FLUSH: begin
                    fir_valid <= 1'b1;
                    fir_d     <= fir_next;
                    flush_cnt <= flush_cnt + 1'b1;
                    if (flush_cnt == FW'(NTAPS - 2)) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                        count      <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_frame_engine.sv
// tb/tb_fir_frame_engine.sv - scoreboard bench for fir_frame_engine with directed frames
module tb_fir_frame_engine;
    localparam int DATA_W = 16, COEF_W = 12, NTAPS = 4, FRAME_LEN = 8, FRAC_SH = 8;

    logic clk = 1'b0;
    logic rst;
    logic signed [DATA_W-1:0] data;
    logic data_valid, data_ready;
    logic coef_we;
    logic [1:0] coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic coef_err;
    logic signed [DATA_W-1:0] fir_d;
    logic fir_valid, frame_done;

    logic signed [DATA_W-1:0] data2;
    logic data_valid2, data_ready2, coef_we2, coef_err2, fir_valid2, frame_done2;
    logic [1:0] coef_addr2;
    logic signed [COEF_W-1:0] coef_wdata2;
    logic signed [DATA_W-1:0] fir_d2;

    always #5 clk = ~clk;

    fir_frame_engine #(.DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(NTAPS),
                       .FRAME_LEN(FRAME_LEN), .FRAC_SH(FRAC_SH)) dut (
        .clk(clk), .rst(rst), .data(data), .data_valid(data_valid), .data_ready(data_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_err(coef_err),
        .fir_d(fir_d), .fir_valid(fir_valid), .frame_done(frame_done));

    // Non-power-of-two tap count so an out-of-range address is representable.
    fir_frame_engine #(.DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(3),
                       .FRAME_LEN(3), .FRAC_SH(FRAC_SH)) dut2 (
        .clk(clk), .rst(rst), .data(data2), .data_valid(data_valid2), .data_ready(data_ready2),
        .coef_we(coef_we2), .coef_addr(coef_addr2), .coef_wdata(coef_wdata2), .coef_err(coef_err2),
        .fir_d(fir_d2), .fir_valid(fir_valid2), .frame_done(frame_done2));

    typedef struct {
        logic signed [DATA_W-1:0] d;
        logic last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;
    int gold[8] = '{100, 100, 100, 100, 100, 90, 70, 40};
    int pat_in[8] = '{100, -100, 200, 0, 50, 0, 0, -256};
    int pat_out[8] = '{500, 250, 900, 150, -56, -512, -768, -1024};

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic push(input int v, input bit last);
        exp_q.push_back('{d: DATA_W'(v), last: last});
    endtask

    task automatic send(input int v);
        int t = 0;
        data = DATA_W'(v);
        data_valid = 1'b1;
        while (!data_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: data_ready stayed 0 for %0d cycles, required 1", t);
        end
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic wr(input int a, input int v, input int exp_err, input string name);
        coef_we = 1'b1;
        coef_addr = 2'(a);
        coef_wdata = COEF_W'(v);
        @(negedge clk);
        coef_we = 1'b0;
        check(name, coef_err, exp_err);
    endtask

    task automatic wr2(input int a, input int v, input int exp_err, input string name);
        coef_we2 = 1'b1;
        coef_addr2 = 2'(a);
        coef_wdata2 = COEF_W'(v);
        @(negedge clk);
        coef_we2 = 1'b0;
        check(name, coef_err2, exp_err);
    endtask

    task automatic load(input int c0, input int c1, input int c2, input int c3);
        wr(0, c0, 0, "coef_wr0");
        wr(1, c1, 0, "coef_wr1");
        wr(2, c2, 0, "coef_wr2");
        wr(3, c3, 0, "coef_wr3");
    endtask

    always @(negedge clk) begin
        if (fir_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got fir_d %0d, required no output", fir_d);
            end else begin
                mon_e = exp_q.pop_front();
                check("fir_d", fir_d, mon_e.d);
                check("frame_done", frame_done, mon_e.last);
            end
        end else if (frame_done === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL frame_done_alone: got frame_done 1 without fir_valid, required 0");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; data = '0; data_valid = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        data2 = '0; data_valid2 = 1'b0; coef_we2 = 1'b0; coef_addr2 = '0; coef_wdata2 = '0;
        repeat (3) @(negedge clk);
        check("ready_in_reset", data_ready, 0);
        check("fir_valid_reset", fir_valid, 0);
        check("fir_d_reset", fir_d, 0);
        check("frame_done_reset", frame_done, 0);
        check("coef_err_reset", coef_err, 0);
        rst = 1'b0;
        #1 check("ready_after_reset", data_ready, 1);

        wr2(3, 5, 1, "coef_err_oob");
        wr2(2, 5, 0, "coef_ok_in_range");

        // Constant frame with a rejected write in RUN.
        load(256, 512, 768, 1024);
        for (int i = 0; i < 8; i++) push(gold[i], i == 7);
        for (int i = 0; i < 8; i++) begin
            if (i == 5) begin
                coef_we = 1'b1; coef_addr = 2'd0; coef_wdata = '0;
            end
            send(10);
            if (i == 5) begin
                coef_we = 1'b0;
                check("coef_err_run", coef_err, 1);
            end
        end

        // Same stream with 3-cycle gaps, then a write in the FLUSH->IDLE cycle.
        for (int i = 0; i < 8; i++) push(gold[i], i == 7);
        for (int i = 0; i < 8; i++) begin
            send(10);
            if (i != 7) repeat (3) @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 2'd0; coef_wdata = '0;
        @(negedge clk);
        coef_we = 1'b0;
        check("coef_err_flush_end", coef_err, 1);
        @(negedge clk);
        check("coef_err_one_cycle", coef_err, 0);

        // Mixed-sign pattern; first accept shares its cycle with an IDLE write.
        for (int i = 0; i < 8; i++) push(pat_out[i], i == 7);
        coef_we = 1'b1; coef_addr = 2'd0; coef_wdata = 12'sd256;
        send(pat_in[0]);
        coef_we = 1'b0;
        check("coef_ok_with_accept", coef_err, 0);
        for (int i = 1; i < 8; i++) send(pat_in[i]);
        repeat (4) @(negedge clk);

        // Saturation, both rails.
        load(2047, 2047, 2047, 2047);
        for (int i = 0; i < 8; i++) push(32767, i == 7);
        for (int i = 0; i < 8; i++) send(32767);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) push(-32768, i == 7);
        for (int i = 0; i < 8; i++) send(-32768);
        repeat (4) @(negedge clk);

        // Reset on the first flush step.
        load(256, 512, 768, 1024);
        for (int i = 0; i < 5; i++) push(100, 1'b0);
        for (int i = 0; i < 8; i++) send(10);
        rst = 1'b1;
        @(negedge clk);
        check("fir_valid_mid_rst", fir_valid, 0);
        check("frame_done_mid_rst", frame_done, 0);
        check("fir_d_mid_rst", fir_d, 0);
        check("ready_mid_rst", data_ready, 0);
        rst = 1'b0;
        #1 check("ready_idle_after_rst", data_ready, 1);
        @(negedge clk);
        check("fir_valid_idle_after_rst", fir_valid, 0);

        load(256, 512, 768, 1024);
        for (int i = 0; i < 8; i++) push(gold[i], i == 7);
        for (int i = 0; i < 8; i++) send(10);
        repeat (6) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
